// File: rtl/lifo_req_driver.sv
// Request/response front end for the 8-entry byte stack: turns each request into one strobe and returns one response.
// Optional build macro LIFO_REQ_DRIVER_STATS_EN adds saturating overflow/underflow counters.
module lifo_req_driver #(
  parameter int DEPTH    = 8,
  parameter int WAIT_CYC = 1
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_op,
  input  logic [7:0] req_data,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_err,
  output logic [3:0] level,
  output logic       lifo_push,
  output logic       lifo_pop,
  output logic       lifo_clr,
  output logic [7:0] lifo_din,
  input  logic [7:0] lifo_dout,
  input  logic       lifo_full,
`ifdef LIFO_REQ_DRIVER_STATS_EN
  output logic [7:0] ovf_cnt,
  output logic [7:0] unf_cnt,
`endif
  input  logic       lifo_empty
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [1:0] OP_PUSH = 2'b01;
  localparam logic [1:0] OP_POP  = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;

  state_t     state_q, state_d;
  logic [1:0] op_q, op_d;
  logic [7:0] data_q, data_d;
  logic       skip_q, skip_d;
  logic       err_q, err_d;
  logic [1:0] wcnt_q, wcnt_d;
  logic [3:0] level_q, level_d;
  logic       push_q, push_d, pop_q, pop_d, iclr_q, iclr_d;
  logic [7:0] din_q, din_d;
  logic [7:0] rsp_data_q, rsp_data_d;
  logic       rsp_err_q, rsp_err_d;

  // The stack's flags lag a cycle; the empty flag carries no extra information over level.
  logic unused_empty;
  assign unused_empty = lifo_empty;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    data_d     = data_q;
    skip_d     = skip_q;
    err_d      = err_q;
    wcnt_d     = wcnt_q;
    level_d    = level_q;
    push_d     = 1'b0;
    pop_d      = 1'b0;
    iclr_d     = 1'b0;
    din_d      = din_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d    = req_op;
          data_d  = req_data;
          state_d = ISSUE;
          skip_d  = 1'b1;
          err_d   = 1'b0;
          case (req_op)
            OP_PUSH: begin
              if (level_q == 4'(DEPTH) || lifo_full) begin
                err_d = 1'b1;
              end else begin
                skip_d = 1'b0;
                push_d = 1'b1;
                din_d  = req_data;
              end
            end
            OP_POP: begin
              if (level_q == 4'd0) err_d = 1'b1;
              else begin
                skip_d = 1'b0;
                pop_d  = 1'b1;
              end
            end
            OP_CLR: begin
              skip_d = 1'b0;
              iclr_d = 1'b1;
            end
            default: ;
          endcase
        end
      end
      // Rejected and nop requests spend this cycle here without a strobe, then respond.
      ISSUE: begin
        if (skip_q) begin
          state_d    = RESP;
          rsp_data_d = 8'h00;
          rsp_err_d  = err_q;
        end else begin
          state_d = WAIT;
          wcnt_d  = 2'd0;
          case (op_q)
            OP_PUSH: level_d = level_q + 4'd1;
            OP_POP:  level_d = level_q - 4'd1;
            default: level_d = 4'd0;
          endcase
        end
      end
      WAIT: begin
        if (wcnt_q == 2'(WAIT_CYC - 1)) begin
          state_d   = RESP;
          rsp_err_d = 1'b0;
          case (op_q)
            OP_POP:  rsp_data_d = lifo_dout;
            OP_PUSH: rsp_data_d = data_q;
            default: rsp_data_d = 8'h00;
          endcase
        end else begin
          wcnt_d = wcnt_q + 2'd1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q    <= IDLE;
      op_q       <= 2'b00;
      data_q     <= 8'h00;
      skip_q     <= 1'b0;
      err_q      <= 1'b0;
      wcnt_q     <= 2'd0;
      level_q    <= 4'd0;
      push_q     <= 1'b0;
      pop_q      <= 1'b0;
      iclr_q     <= 1'b0;
      din_q      <= 8'h00;
      rsp_data_q <= 8'h00;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      data_q     <= data_d;
      skip_q     <= skip_d;
      err_q      <= err_d;
      wcnt_q     <= wcnt_d;
      level_q    <= level_d;
      push_q     <= push_d;
      pop_q      <= pop_d;
      iclr_q     <= iclr_d;
      din_q      <= din_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

`ifdef LIFO_REQ_DRIVER_STATS_EN
  logic [7:0] ovf_q, unf_q;
  logic       rej_entry;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign rej_entry = (state_q == ISSUE) && skip_q && err_q;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      ovf_q <= 8'h00;
      unf_q <= 8'h00;
    end else if (rej_entry) begin
      if (op_q == OP_PUSH) ovf_q <= sat_inc(ovf_q);
      if (op_q == OP_POP)  unf_q <= sat_inc(unf_q);
    end
  end

  assign ovf_cnt = ovf_q;
  assign unf_cnt = unf_q;
`endif

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign level     = level_q;
  assign lifo_push = push_q;
  assign lifo_pop  = pop_q;
  assign lifo_clr  = clr | iclr_q;
  assign lifo_din  = din_q;

endmodule

// File: tb/tb_lifo_req_driver.sv
// Bench for lifo_req_driver with a behavioural byte-stack model and a response scoreboard.
module tb_lifo_req_driver;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_op = 2'b00;
  logic [7:0] req_data = 8'h00;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic [3:0] level;
  logic       lifo_push, lifo_pop, lifo_clr;
  logic [7:0] lifo_din;
  logic [7:0] lifo_dout;
  logic       lifo_full, lifo_empty;
`ifdef LIFO_REQ_DRIVER_STATS_EN
  logic [7:0] ovf_cnt, unf_cnt;
`endif

  lifo_req_driver #(.DEPTH(8), .WAIT_CYC(1)) dut (
    .clk(clk), .clr(clr),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .level(level),
    .lifo_push(lifo_push), .lifo_pop(lifo_pop), .lifo_clr(lifo_clr), .lifo_din(lifo_din),
    .lifo_dout(lifo_dout), .lifo_full(lifo_full),
`ifdef LIFO_REQ_DRIVER_STATS_EN
    .ovf_cnt(ovf_cnt), .unf_cnt(unf_cnt),
`endif
    .lifo_empty(lifo_empty)
  );

  always #5 clk = ~clk;

  // Stack model: registered output, flags follow the registered pointer.
  logic [7:0] mem [0:7];
  int         sp = 0;
  logic [7:0] dout_m = 8'h00;
  always @(posedge clk) begin
    if (lifo_clr) begin
      sp     <= 0;
      dout_m <= 8'h00;
    end else if (lifo_push && sp < 8) begin
      mem[sp] <= lifo_din;
      sp      <= sp + 1;
      dout_m  <= lifo_din;
    end else if (lifo_pop && sp > 0) begin
      dout_m <= mem[sp-1];
      sp     <= sp - 1;
    end
  end
  assign lifo_dout  = dout_m;
  assign lifo_full  = (sp == 8);
  assign lifo_empty = (sp == 0);

  int n_push = 0, n_pop = 0, n_iclr = 0, n_overlap = 0;
  always @(posedge clk) begin
    if (!clr) begin
      if (lifo_push) n_push++;
      if (lifo_pop) n_pop++;
      if (lifo_clr) n_iclr++;
      if (32'(lifo_push) + 32'(lifo_pop) + 32'(lifo_clr) > 1) n_overlap++;
    end
  end

  typedef struct {
    logic [7:0] data;
    logic       err;
    int         lat;
  } exp_t;

  typedef struct {
    logic [1:0] op;
    logic [7:0] din;
    logic [7:0] edata;
    logic       eerr;
    logic [3:0] elvl;
  } vec_t;

  exp_t sb[$];
  int   n_cmp = 0, n_fail = 0;
  int   exp_push = 0, exp_pop = 0, exp_clr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_req(input logic [1:0] op, input logic [7:0] d, input logic [7:0] ed,
                        input logic ee, input logic [3:0] el);
    int   cnt;
    exp_t e;
    e.data = ed;
    e.err  = ee;
    e.lat  = (ee || op == 2'b00) ? 1 : 2;
    sb.push_back(e);
    if (!ee) begin
      if (op == 2'b01) exp_push++;
      if (op == 2'b10) exp_pop++;
      if (op == 2'b11) exp_clr++;
    end
    @(negedge clk);
    cnt = 0;
    while (!req_ready && cnt < 20) begin @(negedge clk); cnt++; end
    req_valid = 1'b1; req_op = op; req_data = d;
    @(negedge clk);
    req_valid = 1'b0; req_op = 2'b00; req_data = 8'h00;
    cnt = 0;
    while (!rsp_valid && cnt < 20) begin @(negedge clk); cnt++; end
    e = sb.pop_front();
    if (!rsp_valid) begin
      check("rsp_timeout", 32'(rsp_valid), 32'd1);
    end else begin
      check("rsp_data", 32'(rsp_data), 32'(e.data));
      check("rsp_err", 32'(rsp_err), 32'(e.err));
      check("rsp_latency", 32'(cnt), 32'(e.lat));
    end
    @(negedge clk);
    check("level", 32'(level), 32'(el));
  endtask

  vec_t vt [9];
  int   cnt;
  int   p0, q0, c0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{2'b10, 8'h00, 8'h00, 1'b1, 4'd0};
    vt[1] = '{2'b00, 8'h5A, 8'h00, 1'b0, 4'd0};
    vt[2] = '{2'b01, 8'h11, 8'h11, 1'b0, 4'd1};
    vt[3] = '{2'b01, 8'h22, 8'h22, 1'b0, 4'd2};
    vt[4] = '{2'b01, 8'h33, 8'h33, 1'b0, 4'd3};
    vt[5] = '{2'b10, 8'h00, 8'h33, 1'b0, 4'd2};
    vt[6] = '{2'b10, 8'h00, 8'h22, 1'b0, 4'd1};
    vt[7] = '{2'b10, 8'h00, 8'h11, 1'b0, 4'd0};
    vt[8] = '{2'b10, 8'h00, 8'h00, 1'b1, 4'd0};

    // Reset
    @(negedge clk); @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_strobes", {29'd0, lifo_push, lifo_pop, lifo_clr}, 32'd1);
    check("rst_lifo_din", 32'(lifo_din), 32'd0);
    clr = 1'b0;

    // Push 0xA5 with cycle-exact strobe/response timing
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b01; req_data = 8'hA5;
    @(negedge clk);
    req_valid = 1'b0; req_op = 2'b00;
    check("a5_push_e0", 32'(lifo_push), 32'd1);
    check("a5_din_e0", 32'(lifo_din), 32'hA5);
    check("a5_ready_e0", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("a5_push_e1", 32'(lifo_push), 32'd0);
    check("a5_valid_e1", 32'(rsp_valid), 32'd0);
    check("a5_level_e1", 32'(level), 32'd1);
    @(negedge clk);
    check("a5_valid_e2", 32'(rsp_valid), 32'd1);
    check("a5_data_e2", 32'(rsp_data), 32'hA5);
    check("a5_err_e2", 32'(rsp_err), 32'd0);
    @(negedge clk);
    check("a5_valid_e3", 32'(rsp_valid), 32'd0);
    check("a5_ready_e3", 32'(req_ready), 32'd1);
    exp_push++;
    do_req(2'b10, 8'h00, 8'hA5, 1'b0, 4'd0);

    // Table-driven vectors
    for (int i = 0; i < 9; i++)
      do_req(vt[i].op, vt[i].din, vt[i].edata, vt[i].eerr, vt[i].elvl);

    // Fill to capacity, then overflow
    for (int i = 0; i < 8; i++)
      do_req(2'b01, 8'(i + 1), 8'(i + 1), 1'b0, 4'(i + 1));
    do_req(2'b01, 8'hEE, 8'h00, 1'b1, 4'd8);
`ifdef LIFO_REQ_DRIVER_STATS_EN
    check("ovf_cnt", 32'(ovf_cnt), 32'd1);
    check("unf_cnt", 32'(unf_cnt), 32'd2);
`endif

    // Response held under backpressure
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_op = 2'b10;
    @(negedge clk);
    req_valid = 1'b0; req_op = 2'b00;
    exp_pop++;
    cnt = 0;
    while (!rsp_valid && cnt < 20) begin @(negedge clk); cnt++; end
    for (int k = 0; k < 5; k++) begin
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_data", 32'(rsp_data), 32'h08);
      check("hold_err", 32'(rsp_err), 32'd0);
      check("hold_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("hold_release_valid", 32'(rsp_valid), 32'd0);
    check("hold_release_ready", 32'(req_ready), 32'd1);
    check("hold_level", 32'(level), 32'd7);

    // Down to level 4, then a clear op
    do_req(2'b10, 8'h00, 8'h07, 1'b0, 4'd6);
    do_req(2'b10, 8'h00, 8'h06, 1'b0, 4'd5);
    do_req(2'b10, 8'h00, 8'h05, 1'b0, 4'd4);
    do_req(2'b11, 8'h00, 8'h00, 1'b0, 4'd0);
    check("clr_strobe_count", 32'(n_iclr), 32'(exp_clr));
`ifdef LIFO_REQ_DRIVER_STATS_EN
    check("ovf_after_clear_op", 32'(ovf_cnt), 32'd1);
`endif

    // Reset asserted while a pop waits for its response
    do_req(2'b01, 8'h77, 8'h77, 1'b0, 4'd1);
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b10;
    @(negedge clk);
    req_valid = 1'b0; req_op = 2'b00;
    exp_pop++;
    @(negedge clk);
    clr = 1'b1;
    #1;
    check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    check("abort_level", 32'(level), 32'd0);
    check("abort_ready", 32'(req_ready), 32'd1);
    check("abort_strobes", {29'd0, lifo_push, lifo_pop, lifo_clr}, 32'd1);
`ifdef LIFO_REQ_DRIVER_STATS_EN
    check("abort_ovf_cnt", 32'(ovf_cnt), 32'd0);
    check("abort_unf_cnt", 32'(unf_cnt), 32'd0);
`endif
    @(negedge clk);
    clr = 1'b0;
    p0 = n_push; q0 = n_pop; c0 = n_iclr;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("post_abort_valid", 32'(rsp_valid), 32'd0);
    end
    check("post_abort_strobes", 32'((n_push - p0) + (n_pop - q0) + (n_iclr - c0)), 32'd0);

    check("push_strobe_count", 32'(n_push), 32'(exp_push));
    check("pop_strobe_count", 32'(n_pop), 32'(exp_pop));
    check("strobe_overlap", 32'(n_overlap), 32'd0);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
